systolic_2x2_feeder: RTL and testbench

//  Operand sequencer directly upstream of the 2x2 sparse systolic array.
//  - Holds the A rows (a0, a1) and B columns (b0, b1) of one K-deep tile in local storage.
//  - On start, clears the PE accumulators and streams one k-step per cycle.
//  - Counts the PE-slots that zero-detect will gate, and pulses done when c00..c11 are final.

---
 rtl/systolic_2x2_feeder.sv | 132 +++++++++++++
 tb/tb_systolic_2x2_feeder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_2x2_feeder.sv
// Operand sequencer for the 2x2 sparse systolic array: holds one K-deep tile of
// A rows / B columns, clears the PE accumulators and streams one k-step per cycle.
module systolic_2x2_feeder #(
   parameter int DW    = 8,
   parameter int K_MAX = 16,
   parameter int KW    = $clog2(K_MAX + 1),
   parameter int AW    = $clog2(K_MAX),
   parameter int SW    = $clog2(4 * K_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [1:0]    wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   output logic          busy,
   output logic          acc_clr,
   output logic [DW-1:0] a0,
   output logic [DW-1:0] a1,
   output logic [DW-1:0] b0,
   output logic [DW-1:0] b1,
   output logic          done,
   output logic [SW-1:0] skip_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t        state;
   logic [KW-1:0] kl;
   logic [KW-1:0] i;

   logic [DW-1:0] mem_a0 [K_MAX];
   logic [DW-1:0] mem_a1 [K_MAX];
   logic [DW-1:0] mem_b0 [K_MAX];
   logic [DW-1:0] mem_b1 [K_MAX];

   logic [DW-1:0] rd_a0, rd_a1, rd_b0, rd_b1;

   assign rd_a0 = mem_a0[i[AW-1:0]];
   assign rd_a1 = mem_a1[i[AW-1:0]];
   assign rd_b0 = mem_b0[i[AW-1:0]];
   assign rd_b1 = mem_b1[i[AW-1:0]];

   // Number of PE-slots zero-detect will gate for one k-step (0..4).
   function automatic logic [2:0] zero_slots(input logic [DW-1:0] x0, x1, y0, y1);
      logic [2:0] s;
      s = 3'd0;
      if (x0 == '0 || y0 == '0) s = s + 3'd1;
      if (x0 == '0 || y1 == '0) s = s + 3'd1;
      if (x1 == '0 || y0 == '0) s = s + 3'd1;
      if (x1 == '0 || y1 == '0) s = s + 3'd1;
      return s;
   endfunction

   // Storage survives rst; only idle-time, in-range writes land.
   always_ff @(posedge clk) begin
      if (wr_en && state == S_IDLE && 32'(wr_addr) < K_MAX) begin
         unique case (wr_sel)
            2'd0: mem_a0[wr_addr] <= wr_data;
            2'd1: mem_a1[wr_addr] <= wr_data;
            2'd2: mem_b0[wr_addr] <= wr_data;
            2'd3: mem_b1[wr_addr] <= wr_data;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         kl       <= '0;
         i        <= '0;
         busy     <= 1'b0;
         acc_clr  <= 1'b0;
         done     <= 1'b0;
         a0       <= '0;
         a1       <= '0;
         b0       <= '0;
         b1       <= '0;
         skip_cnt <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               a0 <= '0;
               a1 <= '0;
               b0 <= '0;
               b1 <= '0;
               if (start) begin
                  kl       <= (32'(k_len) > K_MAX) ? KW'(K_MAX) : k_len;
                  i        <= '0;
                  skip_cnt <= '0;
                  busy     <= 1'b1;
                  acc_clr  <= 1'b1;
                  state    <= S_CLEAR;
               end
            end
            // CLEAR and STREAM share the load path: step i is registered here and
            // presented in the following cycle; i==kl means every step is out.
            S_CLEAR, S_STREAM: begin
               acc_clr <= 1'b0;
               if (i == kl) begin
                  a0    <= '0;
                  a1    <= '0;
                  b0    <= '0;
                  b1    <= '0;
                  state <= S_DRAIN;
               end else begin
                  a0       <= rd_a0;
                  a1       <= rd_a1;
                  b0       <= rd_b0;
                  b1       <= rd_b1;
                  skip_cnt <= skip_cnt + SW'(zero_slots(rd_a0, rd_a1, rd_b0, rd_b1));
                  i        <= i + KW'(1);
                  state    <= S_STREAM;
               end
            end
            S_DRAIN: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_2x2_feeder.sv
// Scoreboard bench for systolic_2x2_feeder: a reference 2x2 MAC array observes the
// streamed operands and each done pulse is checked against a queued expectation.
module tb_systolic_2x2_feeder;

   localparam int DW = 8, K_MAX = 16, KW = 5, AW = 4, SW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [1:0]    wr_sel;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          start;
   logic [KW-1:0] k_len;
   logic          busy, acc_clr, done;
   logic [DW-1:0] a0, a1, b0, b1;
   logic [SW-1:0] skip_cnt;

   systolic_2x2_feeder #(.DW(DW), .K_MAX(K_MAX)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .k_len(k_len), .busy(busy),
      .acc_clr(acc_clr), .a0(a0), .a1(a1), .b0(b0), .b1(b1), .done(done),
      .skip_cnt(skip_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c00, c01, c10, c11, skip, lat;
      string name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   // Reference array model: accumulates observed operands, compares at done.
   logic [15:0] c00, c01, c10, c11;
   int          lat;
   bit          active = 0;

   always @(negedge clk) begin
      if (rst) begin
         active = 0;
      end else if (acc_clr) begin
         c00 = 0; c01 = 0; c10 = 0; c11 = 0;
         lat = 1;
         active = 1;
      end else if (active || done) begin
         lat++;
         c00 += 16'(a0 * b0);
         c01 += 16'(a0 * b1);
         c10 += 16'(a1 * b0);
         c11 += 16'(a1 * b1);
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check({e.name, ".c00"}, int'(c00), e.c00);
               check({e.name, ".c01"}, int'(c01), e.c01);
               check({e.name, ".c10"}, int'(c10), e.c10);
               check({e.name, ".c11"}, int'(c11), e.c11);
               check({e.name, ".skip_cnt"}, int'(skip_cnt), e.skip);
               check({e.name, ".latency"}, lat, e.lat);
            end
            active = 0;
         end
      end
   end

   // All stimulus tasks are entered and left on a negedge.
   task automatic wr(input logic [1:0] sel, input int addr, input int data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = DW'(data);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic load4(input int k, input int va0, input int va1, input int vb0, input int vb1);
      wr(2'd0, k, va0);
      wr(2'd1, k, va1);
      wr(2'd2, k, vb0);
      wr(2'd3, k, vb1);
   endtask

   task automatic push(input string nm, input int e00, e01, e10, e11, sk, lt);
      exp_t e;
      e.name = nm; e.c00 = e00; e.c01 = e01; e.c10 = e10; e.c11 = e11;
      e.skip = sk; e.lat = lt;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) check({nm, ".idle_timeout"}, 1, 0);
      @(negedge clk);
   endtask

   task automatic kick(input string nm, input int kl);
      start = 1'b1; k_len = KW'(kl);
      @(negedge clk);
      start = 1'b0;
      check({nm, ".acc_clr_T+1"}, int'(acc_clr), 1);
   endtask

   task automatic run_tile(input string nm, input int kl);
      kick(nm, kl);
      wait_idle(nm);
   endtask

   task automatic check_idle_zero(input string nm);
      check({nm, ".busy"}, int'(busy), 0);
      check({nm, ".acc_clr"}, int'(acc_clr), 0);
      check({nm, ".done"}, int'(done), 0);
      check({nm, ".ops"}, int'({a0, a1, b0, b1}), 0);
      check({nm, ".skip_cnt"}, int'(skip_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
      start = 1'b0; k_len = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle_zero("reset");

      // Tile 1: plain dense 2-deep tile.
      load4(0, 1, 3, 5, 7);
      load4(1, 2, 4, 6, 8);
      push("t1", 17, 23, 39, 53, 0, 5);
      run_tile("t1", 2);

      // Write and second start while busy must both be ignored.
      push("t5", 17, 23, 39, 53, 0, 5);
      kick("t5", 2);
      start = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = 8'd99;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      wait_idle("t5");
      repeat (3) @(negedge clk);
      check("t5.no_extra_tile", int'(busy), 0);
      push("t5_rerun", 17, 23, 39, 53, 0, 5);
      run_tile("t5_rerun", 2);

      // Tile 2: sparse; gated slots: step0 (a0b0,a0b1,a1b1)=3, step1 (a1b0,a1b1)=2.
      load4(0, 0, 3, 5, 0);
      load4(1, 2, 0, 6, 8);
      push("t2", 12, 16, 15, 0, 5, 5);
      run_tile("t2", 2);

      // Zero-depth tile.
      push("t3", 0, 0, 0, 0, 0, 3);
      run_tile("t3", 0);

      // Depth clamp: a0=1 a1=2 b0=3 b1=0 everywhere, 2 gated slots per step.
      for (int k = 0; k < K_MAX; k++) load4(k, 1, 2, 3, 0);
      push("t4", 48, 0, 96, 0, 32, 19);
      run_tile("t4", 20);

      // Reset mid-tile: no done, idle outputs, then a clean rerun.
      kick("t6", 8);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero("t6_rst");
      repeat (12) @(negedge clk);
      check("t6.no_done_pending", exp_q.size(), 0);
      push("t6_rerun", 24, 0, 48, 0, 16, 11);
      run_tile("t6_rerun", 8);

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
